// File: rtl/snake_input_conditioner.sv
// snake_input_conditioner: synchronise/debounce six buttons, emit start/pause pulses and a committed heading
// Direction requests are rate-limited to one committed turn plus one queued turn per movement step.
module snake_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       dir_init,
  input  logic       dir_en,
  input  logic       move_tick,
  output logic       start_pulse,
  output logic       pause_pulse,
  output logic [1:0] dir,
  output logic       dir_changed
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [5:0]    raw, sync1_q, sync2_q, deb_q, deb_d, prev_q, arm_q, arm_d, press;
  logic [CW-1:0] cnt_q [6];
  logic [CW-1:0] cnt_d [6];
  logic [1:0]    prime_q, prime_d;
  logic [1:0]    req, dir_q, dir_d, pend_q, pend_d;
  logic          req_v, turned_q, turned_d, pv_q, pv_d, chg_q, chg_d, dchg_q;
  logic          start_q, pause_q;

  assign raw = {btn_right, btn_left, btn_down, btn_up, btn_pause, btn_start};

  // A button only arms once a real (post-reset) low sample is seen, so a button held through reset stays silent
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      cnt_d[i] = (sync2_q[i] == deb_q[i] || cnt_q[i] == LAST) ? '0 : cnt_q[i] + CW'(1);
      deb_d[i] = (sync2_q[i] != deb_q[i] && cnt_q[i] == LAST) ? ~deb_q[i] : deb_q[i];
    end
    arm_d   = arm_q | ({6{prime_q[1]}} & ~deb_q & ~sync2_q);
    prime_d = {prime_q[0], 1'b1};
  end

  assign press = deb_q & ~prev_q & arm_q;
  assign req_v = dir_en & |press[5:2];
  assign req   = press[2] ? 2'd0 : press[5] ? 2'd1 : press[3] ? 2'd2 : 2'd3;

  // Valid turns are exactly the perpendicular ones, i.e. those differing in bit 0
  always_comb begin
    dir_d    = dir_q;
    turned_d = turned_q;
    pend_d   = pend_q;
    pv_d     = pv_q;
    if (dir_init) begin
      dir_d    = 2'd1;
      turned_d = 1'b0;
      pv_d     = 1'b0;
    end else if (move_tick && pv_q) begin
      dir_d    = pend_q;
      turned_d = 1'b1;
      pv_d     = req_v && (req[0] ^ pend_q[0]);
      pend_d   = pv_d ? req : pend_q;
    end else if ((move_tick || !turned_q) && req_v && (req[0] ^ dir_q[0])) begin
      dir_d    = req;
      turned_d = 1'b1;
    end else if (move_tick) begin
      turned_d = 1'b0;
    end else if (req_v && (req[0] ^ dir_q[0])) begin
      pend_d = req;
      pv_d   = 1'b1;
    end
    chg_d = (dir_d != dir_q) && !dir_init;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      prev_q   <= '0;
      arm_q    <= '0;
      prime_q  <= '0;
      for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
      start_q  <= 1'b0;
      pause_q  <= 1'b0;
      dir_q    <= 2'd1;
      turned_q <= 1'b0;
      pend_q   <= 2'd0;
      pv_q     <= 1'b0;
      chg_q    <= 1'b0;
      dchg_q   <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      prev_q   <= deb_q;
      arm_q    <= arm_d;
      prime_q  <= prime_d;
      for (int i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
      start_q  <= press[0];
      pause_q  <= press[1];
      dir_q    <= dir_d;
      turned_q <= turned_d;
      pend_q   <= pend_d;
      pv_q     <= pv_d;
      chg_q    <= chg_d;
      dchg_q   <= chg_q;
    end
  end

  assign start_pulse = start_q;
  assign pause_pulse = pause_q;
  assign dir         = dir_q;
  assign dir_changed = dchg_q;
endmodule

// File: tb/tb_snake_input_conditioner.sv
// tb_snake_input_conditioner: directed stimulus checked every cycle against a behavioural model, plus literal spot checks
module tb_snake_input_conditioner;
  localparam int DC = 4;

  logic clk = 1'b0, rst_n = 1'b1;
  logic btn_start = 0, btn_pause = 0, btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0;
  logic dir_init = 0, dir_en = 0, move_tick = 0;
  logic start_pulse, pause_pulse, dir_changed;
  logic [1:0] dir;

  int checks = 0, failures = 0;
  int n_start = 0, n_pause = 0, n_chg = 0, c0, s0;

  snake_input_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start(btn_start), .btn_pause(btn_pause), .btn_up(btn_up),
    .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .dir_init(dir_init), .dir_en(dir_en), .move_tick(move_tick),
    .start_pulse(start_pulse), .pause_pulse(pause_pulse),
    .dir(dir), .dir_changed(dir_changed)
  );

  always #5 clk = ~clk;

  // Behavioural model: samples reach the debouncer two edges late; a level flips after DC consecutive disagreeing samples
  logic [5:0] raw_b;
  assign raw_b = {btn_right, btn_left, btn_down, btn_up, btn_pause, btn_start};
  int m_run [6];
  bit [5:0] m_s1, m_s2, m_deb, m_arm, m_ev;
  int m_dir = 1, m_pend = 0, m_req, m_old;
  bit m_turn, m_pv, m_chg, m_rv, e_start, e_pause, e_chg;

  function automatic bit ok(int r, int h);
    return r != h && r != (h + 2) % 4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_deb = 0; m_arm = 0; m_ev = 0;
      for (int b = 0; b < 6; b++) m_run[b] = 0;
      m_dir = 1; m_pend = 0; m_turn = 0; m_pv = 0; m_chg = 0;
      e_start = 0; e_pause = 0; e_chg = 0;
    end else begin
      e_start = m_ev[0];
      e_pause = m_ev[1];
      e_chg   = m_chg;
      m_rv  = dir_en && (m_ev[5:2] != 0);
      m_req = m_ev[2] ? 0 : m_ev[5] ? 1 : m_ev[3] ? 2 : 3;
      m_old = m_dir;
      if (dir_init) begin
        m_dir = 1; m_turn = 0; m_pv = 0;
      end else if (move_tick) begin
        if (m_pv) begin
          m_dir = m_pend; m_turn = 1; m_pv = 0;
          if (m_rv && ok(m_req, m_dir)) begin m_pend = m_req; m_pv = 1; end
        end else begin
          m_turn = 0;
          if (m_rv && ok(m_req, m_dir)) begin m_dir = m_req; m_turn = 1; end
        end
      end else if (m_rv && ok(m_req, m_dir)) begin
        if (!m_turn) begin m_dir = m_req; m_turn = 1; end
        else begin m_pend = m_req; m_pv = 1; end
      end
      m_chg = !dir_init && m_dir != m_old;
      for (int b = 0; b < 6; b++) begin
        m_ev[b] = 0;
        m_run[b] = (m_s2[b] != m_deb[b]) ? m_run[b] + 1 : 0;
        if (m_run[b] == DC) begin
          m_deb[b] = !m_deb[b];
          m_run[b] = 0;
          m_ev[b]  = m_deb[b] && m_arm[b];
        end
      end
      m_arm = m_arm | ~raw_b;
      m_s2 = m_s1;
      m_s1 = raw_b;
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({start_pulse, pause_pulse, dir, dir_changed} !== {e_start, e_pause, 2'(m_dir), e_chg}) begin
      failures++;
      $display("FAIL model t=%0t got sp=%b pp=%b dir=%0d dc=%b want sp=%b pp=%b dir=%0d dc=%b",
               $time, start_pulse, pause_pulse, dir, dir_changed, e_start, e_pause, m_dir, e_chg);
    end
    if (start_pulse) n_start++;
    if (pause_pulse) n_pause++;
    if (dir_changed) n_chg++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // m: [0]=up [1]=right [2]=down [3]=left
  task automatic press(input logic [3:0] m);
    {btn_left, btn_down, btn_right, btn_up} = m;
    cyc(8);
    {btn_left, btn_down, btn_right, btn_up} = 4'b0;
    cyc(8);
  endtask

  task automatic move();
    move_tick = 1;
    cyc(1);
    move_tick = 0;
    cyc(3);
  endtask

  initial begin
    #1 rst_n = 0;
    cyc(3);
    chk("rst_dir", dir, 1);
    chk("rst_start", start_pulse, 0);
    chk("rst_chg", dir_changed, 0);
    #3 rst_n = 1;
    cyc(6);
    btn_start = 1;
    cyc(6);
    chk("start_early", start_pulse, 0);
    cyc(1);
    chk("start_lat", start_pulse, 1);
    cyc(1);
    chk("start_one", start_pulse, 0);
    cyc(50);
    chk("start_count", n_start, 1);
    btn_start = 0;
    cyc(10);
    repeat (3) begin
      btn_pause = 1; cyc(3);
      btn_pause = 0; cyc(2);
    end
    chk("pause_bounce", n_pause, 0);
    btn_pause = 1;
    cyc(12);
    chk("pause_count", n_pause, 1);
    btn_pause = 0;
    cyc(10);
    dir_en = 1;
    press(4'b1000);
    chk("left_drop", dir, 1);
    c0 = n_chg;
    press(4'b0001);
    chk("up_dir", dir, 0);
    chk("up_chg", n_chg - c0, 1);
    move();
    dir_init = 1; cyc(1); dir_init = 0; cyc(2);
    chk("init_right", dir, 1);
    press(4'b0001);
    press(4'b0100);
    chk("down_drop", dir, 0);
    press(4'b1000);
    chk("pend_hold", dir, 0);
    c0 = n_chg;
    move();
    chk("pend_apply", dir, 3);
    chk("pend_chg", n_chg - c0, 1);
    move();
    press(4'b0011);
    chk("prio_up", dir, 0);
    press(4'b1000);
    c0 = n_chg;
    btn_down = 1;
    cyc(6);
    dir_init = 1;
    cyc(1);
    dir_init = 0;
    cyc(2);
    btn_down = 0;
    cyc(8);
    chk("init_dir", dir, 1);
    chk("init_nochg", n_chg - c0, 0);
    move();
    chk("init_pv", dir, 1);
    press(4'b0001);
    press(4'b0010);
    btn_start = 1;
    cyc(3);
    #3 rst_n = 0;
    cyc(1);
    chk("mid_rst_dir", dir, 1);
    chk("mid_rst_sp", start_pulse, 0);
    chk("mid_rst_dc", dir_changed, 0);
    #3 rst_n = 1;
    s0 = n_start;
    cyc(20);
    chk("held_nopulse", n_start - s0, 0);
    move();
    chk("rst_pend", dir, 1);
    btn_start = 0;
    cyc(10);
    s0 = n_start;
    btn_start = 1;
    cyc(10);
    chk("repress", n_start - s0, 1);
    btn_start = 0;
    cyc(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
